// File: rtl/regfile_scoreboard.sv
// Integer register file with same-cycle writeback bypass and a
// per-register pending scoreboard that stalls RAW/WAW hazards.
module regfile_scoreboard #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [BUS_WIDTH-1:0]  rs1_data,
  output logic [BUS_WIDTH-1:0]  rs2_data,
  input  logic                  issue_en,
  input  logic                  rs1_use,
  input  logic                  rs2_use,
  input  logic                  rd_we,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [BUS_WIDTH-1:0]  wb_data,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pending_cnt
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam int CW       = ADDR_WIDTH + 1;

  logic [BUS_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]  pend_q, pend_d;
  logic [NUM_REGS-1:0]  wb_dec, rd_dec, peff;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 acc, inc, dec;

  always_comb begin
    wb_dec = '0;
    if (wb_en) wb_dec[wb_addr] = 1'b1;
  end

  // A writeback landing this cycle satisfies the hazard on that register
  assign peff  = pend_q & ~wb_dec;
  assign stall = ~rst & issue_en &
                 ((rs1_use & peff[rs1_addr]) |
                  (rs2_use & peff[rs2_addr]) |
                  (rd_we   & peff[rd_addr]));
  assign acc   = issue_en & ~stall & rd_we &
                 (rd_addr != '0);

  always_comb begin
    rd_dec = '0;
    if (acc) rd_dec[rd_addr] = 1'b1;
  end

  // Set wins over clear: the newer producer owns the register
  always_comb begin
    pend_d    = (pend_q & ~wb_dec) | rd_dec;
    pend_d[0] = 1'b0;
  end

  assign inc   = acc & ~pend_q[rd_addr];
  assign dec   = wb_en & (wb_addr != '0) &
                 pend_q[wb_addr] &
                 ~(acc & (rd_addr == wb_addr));
  assign cnt_d = cnt_q + CW'(inc) - CW'(dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (!rst && rs1_addr != '0)
      rs1_data = (wb_en && wb_addr == rs1_addr) ?
                 wb_data : regs_q[rs1_addr];
  end

  always_comb begin
    rs2_data = '0;
    if (!rst && rs2_addr != '0)
      rs2_data = (wb_en && wb_addr == rs2_addr) ?
                 wb_data : regs_q[rs2_addr];
  end

  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against
// an array-based reference of registers and pending flags.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        issue_en, rs1_use, rs2_use, rd_we, wb_en;
  logic        stall;
  logic [5:0]  pending_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mregs [32];
  bit          mpend [32];

  regfile_scoreboard #(.BUS_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_en(issue_en), .rs1_use(rs1_use),
    .rs2_use(rs2_use), .rd_we(rd_we),
    .rd_addr(rd_addr), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic bit owed(input logic [4:0] r);
    return mpend[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic bit mstall();
    return issue_en && ((rs1_use && owed(rs1_addr)) ||
                        (rs2_use && owed(rs2_addr)) ||
                        (rd_we && owed(rd_addr)));
  endfunction

  function automatic int mcount();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(mpend[r]);
    return n;
  endfunction

  task automatic mreset();
    for (int r = 0; r < 32; r++) begin
      mregs[r] = '0;
      mpend[r] = 1'b0;
    end
  endtask

  task automatic idle();
    issue_en = 0; rs1_use = 0; rs2_use = 0; rd_we = 0;
    rd_addr = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    rs1_addr = 0; rs2_addr = 0;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic tick();
    bit acc;
    acc = issue_en && !mstall() && rd_we && rd_addr != 0;
    @(posedge clk);
    if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
    if (wb_en) mpend[wb_addr] = 1'b0;
    if (acc) mpend[rd_addr] = 1'b1;
    mpend[0] = 1'b0;
    #2;
    chk("cnt_model", 32'(pending_cnt), 32'(mcount()));
  endtask

  task automatic check_comb();
    chk("rs1_model", rs1_data, mread(rs1_addr));
    chk("rs2_model", rs2_data, mread(rs2_addr));
    chk("stall_model", 32'(stall), 32'(mstall()));
  endtask

  initial begin
    idle();
    mreset();
    rst = 1'b1;
    wb_en = 1; wb_addr = 5; wb_data = 32'hFFFF_0000;
    rs1_addr = 5;
    #3;
    chk("rst_no_fwd", rs1_data, 32'h0);
    #9;
    rst = 1'b0;
    idle();

    // 1: all registers read zero after reset
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk("rst_rs1", rs1_data, 32'h0);
      chk("rst_rs2", rs2_data, 32'h0);
    end
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_cnt", 32'(pending_cnt), 32'h0);

    // 2: bypass and x0 discard
    @(posedge clk); #2;
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    rs1_addr = 5;
    settle();
    chk("byp_same", rs1_data, 32'hDEADBEEF);
    tick();
    wb_en = 0;
    settle();
    chk("byp_next", rs1_data, 32'hDEADBEEF);
    wb_en = 1; wb_addr = 0; wb_data = 32'h1234;
    rs1_addr = 0;
    settle();
    chk("x0_same", rs1_data, 32'h0);
    tick();
    wb_en = 0;
    settle();
    chk("x0_next", rs1_data, 32'h0);

    // 3: RAW hazard resolved by same-cycle writeback
    idle();
    issue_en = 1; rd_we = 1; rd_addr = 7;
    settle();
    chk("raw_iss_stall", 32'(stall), 32'h0);
    tick();
    chk("raw_cnt1", 32'(pending_cnt), 32'h1);
    idle();
    issue_en = 1; rs1_use = 1; rs1_addr = 7;
    settle();
    chk("raw_stall", 32'(stall), 32'h1);
    wb_en = 1; wb_addr = 7; wb_data = 42;
    #1;
    chk("raw_wb_stall", 32'(stall), 32'h0);
    chk("raw_wb_data", rs1_data, 32'd42);
    tick();
    chk("raw_cnt0", 32'(pending_cnt), 32'h0);

    // 4: WAW hazard
    idle();
    issue_en = 1; rd_we = 1; rd_addr = 9;
    tick();
    settle();
    chk("waw_stall", 32'(stall), 32'h1);
    tick();
    chk("waw_hold", 32'(pending_cnt), 32'h1);
    wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    settle();
    chk("waw_wb_stall", 32'(stall), 32'h0);
    tick();
    chk("waw_own", 32'(pending_cnt), 32'h1);
    idle();
    issue_en = 1; rs2_use = 1; rs2_addr = 9;
    settle();
    chk("waw_still", 32'(stall), 32'h1);
    idle();
    wb_en = 1; wb_addr = 9; wb_data = 32'h100;
    tick();
    chk("waw_clr", 32'(pending_cnt), 32'h0);

    // 5: rd=x0 never becomes pending
    idle();
    issue_en = 1; rd_we = 1; rd_addr = 0;
    settle();
    chk("x0_stall", 32'(stall), 32'h0);
    tick();
    chk("x0_cnt", 32'(pending_cnt), 32'h0);

    // 6: reset mid-operation
    for (int r = 1; r <= 3; r++) begin
      idle();
      issue_en = 1; rd_we = 1; rd_addr = 5'(r);
      tick();
    end
    chk("pre_rst_cnt", 32'(pending_cnt), 32'h3);
    idle();
    issue_en = 1; rs1_use = 1; rs1_addr = 5;
    rs2_addr = 1;
    wb_en = 1; wb_addr = 5; wb_data = 32'h5555;
    rst = 1'b1;
    #1;
    mreset();
    chk("mid_rst_rs1", rs1_data, 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_cnt", 32'(pending_cnt), 32'h0);
    #3;
    rst = 1'b0;
    idle();
    @(posedge clk); #2;
    wb_en = 1; wb_addr = 2; wb_data = 7;
    tick();
    wb_en = 0; rs1_addr = 2;
    settle();
    chk("post_rst_x2", rs1_data, 32'd7);
    chk("post_rst_cnt", 32'(pending_cnt), 32'h0);

    // Random traffic against the reference
    for (int n = 0; n < 400; n++) begin
      idle();
      issue_en = 1'($urandom_range(0, 1));
      rs1_use  = 1'($urandom_range(0, 1));
      rs2_use  = 1'($urandom_range(0, 1));
      rd_we    = 1'($urandom_range(0, 1));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 31));
      rd_addr  = 5'($urandom_range(0, 7));
      wb_en    = 1'($urandom_range(0, 1));
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      settle();
      check_comb();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
